// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and FSM state type for the RV32M multiply/divide unit
package muldiv_pkg;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand latch, shift-add / restoring-divide step and sign fix-up
module muldiv_datapath
   import muldiv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        i_load,
   input  logic        i_step,
   input  logic        i_last,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_special,
   output logic [31:0] o_result
);
   logic [2:0]  r_op;
   logic        r_neg;
   logic [63:0] r_acc;
   logic [63:0] r_opa;
   logic [31:0] r_opb;
   logic        w_sa, w_sb, w_div0, w_ovf, w_ge;
   logic [31:0] w_mag_a, w_mag_b, w_spec, w_q_n, w_dmag, w_dres, w_mres, w_res;
   logic [32:0] w_shr, w_rem_n;
   logic [63:0] w_mul_acc, w_prod;
   assign w_sa      = !(i_funct3 == F3_MULHU || i_funct3 == F3_DIVU || i_funct3 == F3_REMU) && i_a[31];
   assign w_sb      = (i_funct3 == F3_MUL || i_funct3 == F3_MULH || i_funct3 == F3_DIV || i_funct3 == F3_REM) && i_b[31];
   assign w_mag_a   = w_sa ? -i_a : i_a;
   assign w_mag_b   = w_sb ? -i_b : i_b;
   assign w_div0    = i_funct3[2] && i_b == 32'h0;
   assign w_ovf     = i_funct3[2] && !i_funct3[0] && i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF;
   assign o_special = w_div0 || w_ovf;
   assign w_spec    = i_funct3[1] ? (w_div0 ? i_a : 32'h0) : (w_div0 ? 32'hFFFF_FFFF : 32'h8000_0000);
   // multiply: r_opa is the left-shifting multiplicand, r_opb the right-shifting multiplier
   assign w_mul_acc = r_opb[0] ? r_acc + r_opa : r_acc;
   // divide: r_acc holds the partial remainder, r_opa[31:0] the dividend turning into the quotient
   assign w_shr     = {r_acc[31:0], r_opa[31]};
   assign w_ge      = w_shr >= {1'b0, r_opb};
   assign w_rem_n   = w_ge ? w_shr - {1'b0, r_opb} : w_shr;
   assign w_q_n     = {r_opa[30:0], w_ge};
   assign w_prod    = r_neg ? -w_mul_acc : w_mul_acc;
   assign w_mres    = r_op == F3_MUL ? w_prod[31:0] : w_prod[63:32];
   assign w_dmag    = r_op[1] ? w_rem_n[31:0] : w_q_n;
   assign w_dres    = r_neg ? -w_dmag : w_dmag;
   assign w_res     = r_op[2] ? w_dres : w_mres;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_op     <= 3'b0;
         r_neg    <= 1'b0;
         r_acc    <= 64'h0;
         r_opa    <= 64'h0;
         r_opb    <= 32'h0;
         o_result <= 32'h0;
      end else if (i_load) begin
         r_op  <= i_funct3;
         r_neg <= (i_funct3[2] && i_funct3[1]) ? w_sa : w_sa ^ w_sb;
         r_acc <= 64'h0;
         r_opa <= {32'h0, w_mag_a};
         r_opb <= w_mag_b;
         if (o_special) o_result <= w_spec;
      end else if (i_step) begin
         r_acc <= r_op[2] ? {31'h0, w_rem_n} : w_mul_acc;
         r_opa <= r_op[2] ? {32'h0, w_q_n} : {r_opa[62:0], 1'b0};
         r_opb <= r_op[2] ? r_opb : {1'b0, r_opb[31:1]};
         if (i_last) o_result <= w_res;
      end
   end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M unit for the EX stage; FSM, iteration counter and stall/done handshake
module ex_muldiv
   import muldiv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic        flush_i,
   input  logic [9:0]  funct_i,
   input  logic [31:0] RS1data_i,
   input  logic [31:0] RS2data_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] result_o
);
   state_t     r_state;
   logic [4:0] r_cnt;
   logic       w_accept, w_special, w_calc, w_step, w_last;
   assign w_accept = r_state == IDLE && valid_i && funct_i[9:3] == FUNCT7_MULDIV && !flush_i;
   assign w_calc   = r_state == CALC;
   assign w_step   = w_calc && !flush_i;
   assign w_last   = w_step && r_cnt == 5'd31;
   // combinational so ID/EX is frozen at the very edge the op is accepted
   assign stall_o  = rst_i && (w_accept || w_calc);
   assign done_o   = r_state == DONE;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_cnt   <= 5'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= 5'd0;
               if (w_accept) r_state <= w_special ? DONE : CALC;
            end
            CALC: begin
               r_cnt <= flush_i ? 5'd0 : r_cnt + 5'd1;
               if (flush_i) r_state <= IDLE;
               else if (r_cnt == 5'd31) r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   muldiv_datapath u_dp (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_load    (w_accept),
      .i_step    (w_step),
      .i_last    (w_last),
      .i_funct3  (funct_i[2:0]),
      .i_a       (RS1data_i),
      .i_b       (RS2data_i),
      .o_special (w_special),
      .o_result  (result_o)
   );
endmodule
